// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame reader.
//   - 640x480@60 timing constants and a vga_timing_t description
//   - pixel_t {r,g,b} payload and vga_ctl_t sideband flags
//   - sync polarity constants and generator state enum
`timescale 1ns/1ps
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    localparam int unsigned PIX_W = 8;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h: '{active: 16'(VGA_H_ACTIVE), fp: 16'(VGA_H_FP),
             sync: 16'(VGA_H_SYNC), bp: 16'(VGA_H_BP)},
        v: '{active: 16'(VGA_V_ACTIVE), fp: 16'(VGA_V_FP),
             sync: 16'(VGA_V_SYNC), bp: 16'(VGA_V_BP)}
    };

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } pixel_t;

    // Timing flags carried down the read-latency delay line (1 = active)
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } vga_ctl_t;

    typedef enum logic {
        GEN_IDLE = 1'b0,
        GEN_RUN  = 1'b1
    } gen_state_t;

    function automatic int unsigned axis_total(input vga_axis_t a);
        return 32'(a.active) + 32'(a.fp) + 32'(a.sync) + 32'(a.bp);
    endfunction

    function automatic int unsigned axis_sync_start(input vga_axis_t a);
        return 32'(a.active) + 32'(a.fp);
    endfunction

    function automatic int unsigned axis_sync_end(input vga_axis_t a);
        return 32'(a.active) + 32'(a.fp) + 32'(a.sync);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters with sync windows and active flag.
// All flags are registered together with the counters, so they describe
// the position currently held in o_h_cnt/o_v_cnt.
//   clk, rstn      clock, async active-low reset
//   i_enable       low forces idle with counters at (0,0)
//   o_h_cnt/o_v_cnt current position
//   o_active       inside active region (and running)
//   o_hsync_act    inside horizontal sync window (1 = active)
//   o_vsync_act    inside vertical sync window (1 = active)
//   o_frame_first  position (0,0) of a running frame
`timescale 1ns/1ps
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter vga_timing_t TIMING = VGA_640X480_60,
    parameter int unsigned H_W    = 10,
    parameter int unsigned V_W    = 10
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           i_enable,
    output logic [H_W-1:0] o_h_cnt,
    output logic [V_W-1:0] o_v_cnt,
    output logic           o_active,
    output logic           o_hsync_act,
    output logic           o_vsync_act,
    output logic           o_frame_first
);

    localparam int unsigned H_TOTAL  = axis_total(TIMING.h);
    localparam int unsigned V_TOTAL  = axis_total(TIMING.v);
    localparam int unsigned H_ACTIVE = 32'(TIMING.h.active);
    localparam int unsigned V_ACTIVE = 32'(TIMING.v.active);
    localparam int unsigned H_SYNC_S = axis_sync_start(TIMING.h);
    localparam int unsigned H_SYNC_E = axis_sync_end(TIMING.h);
    localparam int unsigned V_SYNC_S = axis_sync_start(TIMING.v);
    localparam int unsigned V_SYNC_E = axis_sync_end(TIMING.v);

    gen_state_t     r_state;
    gen_state_t     w_state_nxt;
    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    logic [H_W-1:0] w_h_nxt;
    logic [V_W-1:0] w_v_nxt;
    logic           r_active;
    logic           r_hs;
    logic           r_vs;
    logic           r_first;
    logic           w_active_nxt;
    logic           w_hs_nxt;
    logic           w_vs_nxt;
    logic           w_first_nxt;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= GEN_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: run while enabled; the first running cycle sits at (0,0)
    always_comb begin
        w_state_nxt = GEN_IDLE;
        if (i_enable) w_state_nxt = GEN_RUN;
    end

    // Next counter position and the flags that describe it
    always_comb begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (w_state_nxt == GEN_RUN && r_state == GEN_RUN) begin
            if (32'(r_h_cnt) == H_TOTAL - 1) begin
                w_h_nxt = '0;
                if (32'(r_v_cnt) != V_TOTAL - 1) w_v_nxt = r_v_cnt + V_W'(1);
            end else begin
                w_h_nxt = r_h_cnt + H_W'(1);
                w_v_nxt = r_v_cnt;
            end
        end
        w_active_nxt = (w_state_nxt == GEN_RUN) &&
                       (32'(w_h_nxt) < H_ACTIVE) && (32'(w_v_nxt) < V_ACTIVE);
        w_hs_nxt     = (w_state_nxt == GEN_RUN) &&
                       (32'(w_h_nxt) >= H_SYNC_S) && (32'(w_h_nxt) < H_SYNC_E);
        w_vs_nxt     = (w_state_nxt == GEN_RUN) &&
                       (32'(w_v_nxt) >= V_SYNC_S) && (32'(w_v_nxt) < V_SYNC_E);
        w_first_nxt  = w_active_nxt && (w_h_nxt == '0) && (w_v_nxt == '0);
    end

    // Counter and flag registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_active <= 1'b0;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_first  <= 1'b0;
        end else begin
            r_h_cnt  <= w_h_nxt;
            r_v_cnt  <= w_v_nxt;
            r_active <= w_active_nxt;
            r_hs     <= w_hs_nxt;
            r_vs     <= w_vs_nxt;
            r_first  <= w_first_nxt;
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_active      = r_active;
    assign o_hsync_act   = r_hs;
    assign o_vsync_act   = r_vs;
    assign o_frame_first = r_first;

endmodule

// File: rtl/vga_frame_reader.sv
// VGA video source: timing generation, frame-buffer address generation
// with optional 2^SCALE_SH pixel replication, and a MEM_LAT-deep delay
// line that realigns timing with returned pixel data.
//   clk, rstn            pixel clock, async active-low reset
//   i_enable             run timing; low holds the generator idle
//   o_rd_en, o_rd_addr   frame-buffer read strobe / linear address
//   i_rd_data            {R,G,B}, valid MEM_LAT cycles after o_rd_en
//   o_vsync/o_hsync/o_de video timing, MEM_LAT+1 cycles after the counters
//   o_r/g/b_data         pixel, zero while o_de is low
//   o_frame_start        one-cycle pulse with output pixel (0,0)
`timescale 1ns/1ps
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned SCALE_SH = 1,
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned ADDR_W   = $clog2((H_ACTIVE >> SCALE_SH) * (V_ACTIVE >> SCALE_SH))
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_enable,
    output logic               o_rd_en,
    output logic [ADDR_W-1:0]  o_rd_addr,
    input  logic [3*WIDTH-1:0] i_rd_data,
    output logic               o_vsync,
    output logic               o_hsync,
    output logic               o_de,
    output logic [WIDTH-1:0]   o_r_data,
    output logic [WIDTH-1:0]   o_g_data,
    output logic [WIDTH-1:0]   o_b_data,
    output logic               o_frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W      = $clog2(H_TOTAL);
    localparam int unsigned V_W      = $clog2(V_TOTAL);
    localparam int unsigned SUB_MASK = (1 << SCALE_SH) - 1;
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE >> SCALE_SH);

    localparam vga_timing_t TIMING = '{
        h: '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)},
        v: '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)}
    };

    logic [H_W-1:0]    w_h_cnt;
    logic [V_W-1:0]    w_v_cnt;
    logic              w_active;
    logic              w_hs;
    logic              w_vs;
    logic              w_first;
    logic              w_col_step;
    logic              w_line_end;
    logic              w_base_step;
    logic              w_frame_wrap;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_line_base;
    vga_ctl_t          w_ctl;
    vga_ctl_t          w_tap;
    vga_ctl_t          r_dly [MEM_LAT];
    logic              r_de;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_frame_start;
    logic [WIDTH-1:0]  r_r;
    logic [WIDTH-1:0]  r_g;
    logic [WIDTH-1:0]  r_b;

    vga_timing_gen #(
        .TIMING (TIMING),
        .H_W    (H_W),
        .V_W    (V_W)
    ) u_timing (
        .clk           (clk),
        .rstn          (rstn),
        .i_enable      (i_enable),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_active      (w_active),
        .o_hsync_act   (w_hs),
        .o_vsync_act   (w_vs),
        .o_frame_first (w_first)
    );

    // Column advances on the last replica of a source pixel; the line base
    // advances after the last replica of a source line.
    assign w_col_step   = (32'(w_h_cnt) & SUB_MASK) == SUB_MASK;
    assign w_line_end   = 32'(w_h_cnt) == H_ACTIVE - 1;
    assign w_base_step  = (32'(w_v_cnt) & SUB_MASK) == SUB_MASK;
    assign w_frame_wrap = (32'(w_h_cnt) == H_TOTAL - 1) && (32'(w_v_cnt) == V_TOTAL - 1);

    // Incremental address generation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col       <= '0;
            r_line_base <= '0;
        end else if (!i_enable) begin
            r_col       <= '0;
            r_line_base <= '0;
        end else begin
            if (w_active) begin
                if (w_line_end) begin
                    r_col <= '0;
                    if (w_base_step) r_line_base <= r_line_base + LINE_STEP;
                end else if (w_col_step) begin
                    r_col <= r_col + ADDR_W'(1);
                end
            end
            if (w_frame_wrap) r_line_base <= '0;
        end
    end

    assign o_rd_en   = w_active;
    assign o_rd_addr = r_line_base + r_col;

    assign w_ctl = '{de: w_active, hs: w_hs, vs: w_vs, fs: w_first};
    assign w_tap = r_dly[MEM_LAT-1];

    // Delay line matching the frame-buffer read latency
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(MEM_LAT); i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= w_ctl;
            for (int i = 1; i < int'(MEM_LAT); i++) r_dly[i] <= r_dly[i-1];
        end
    end

    // Output register: timing and RGB leave together, RGB blanked outside de
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_de          <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
            r_r           <= '0;
            r_g           <= '0;
            r_b           <= '0;
        end else begin
            r_de          <= w_tap.de;
            r_hsync       <= w_tap.hs ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_tap.vs ? SYNC_POL : ~SYNC_POL;
            r_frame_start <= w_tap.fs;
            r_r           <= w_tap.de ? i_rd_data[3*WIDTH-1 -: WIDTH] : '0;
            r_g           <= w_tap.de ? i_rd_data[2*WIDTH-1 -: WIDTH] : '0;
            r_b           <= w_tap.de ? i_rd_data[WIDTH-1:0]          : '0;
        end
    end

    assign o_de          = r_de;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_frame_start = r_frame_start;
    assign o_r_data      = r_r;
    assign o_g_data      = r_g;
    assign o_b_data      = r_b;

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Video stream source for the display path. It generates VGA timing (`hsync`, `vsync`, `de`) and fetches pixels from a synchronous-read RGB frame buffer. It emits the same `vsync`/`hsync`/`de` + R/G/B stream that the downstream pixel filters (grayscale, threshold) consume. Optional 2x upscaling lets a 320x240 buffer drive a 640x480 display.

## Interface
Parameters:
- `WIDTH`, 8, bits per colour channel
- `H_ACTIVE` / `H_FP` / `H_SYNC` / `H_BP`, 640 / 16 / 96 / 48, horizontal timing in pixels
- `V_ACTIVE` / `V_FP` / `V_SYNC` / `V_BP`, 480 / 10 / 2 / 33, vertical timing in lines
- `SYNC_POL`, 0, sync active level (0 = active-low)
- `SCALE_SH`, 1, upscale shift (0 = 1:1, 1 = 2x2 replication)
- `MEM_LAT`, 2, frame-buffer read latency in cycles (1..4)
- `ADDR_W`, derived, $clog2((H_ACTIVE>>SCALE_SH)*(V_ACTIVE>>SCALE_SH))

Ports:
- `clk`  in  1  pixel clock
- `rstn`  in  1  asynchronous, active-low reset
- `i_enable`  in  1  run timing; low holds the generator idle
- `o_rd_en`  out  1  frame-buffer read strobe
- `o_rd_addr`  out  ADDR_W  linear read address
- `i_rd_data`  in  3*WIDTH  {R,G,B}, valid MEM_LAT cycles after `o_rd_en`
- `o_vsync`, `o_hsync`, `o_de`  out  1 each  video timing
- `o_r_data`, `o_g_data`, `o_b_data`  out  WIDTH each  pixel
- `o_frame_start`  out  1  one-cycle pulse coincident with output pixel (0,0)

## Operation
- Counters: `h_cnt` runs 0..H_TOTAL-1. `v_cnt` runs 0..V_TOTAL-1 and increments when `h_cnt` wraps. H_TOTAL and V_TOTAL are the sums of the four segments.
- Active region: `h_cnt < H_ACTIVE && v_cnt < V_ACTIVE`.
- Sync windows:
  - `hsync` is active for `H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC`.
  - `vsync` uses the same construction vertically.
  - Both are driven at level `SYNC_POL` when active and `~SYNC_POL` otherwise.
- Reads: `o_rd_en` equals the active-region flag.
- Address generation is incremental, with no multiplier:
  - `col` advances once every 2^SCALE_SH active pixels.
  - `o_rd_addr = line_base + col`.
  - `line_base` adds `H_ACTIVE>>SCALE_SH` at the end of each active line where `v_cnt[SCALE_SH-1:0]` is all ones. For SCALE_SH=0 this happens on every line.
  - `line_base` clears at frame wrap.
- Delay line: `de`, `hsync`, `vsync` and frame-start are delayed MEM_LAT cycles so they align with `i_rd_data`, then registered once more together with RGB.
- Blanking: when the delayed `de` is low, RGB outputs are 0.
- Enable control:
  - While `i_enable` is 0, counters, `col` and `line_base` are held at 0 and `o_rd_en` is 0.
  - When `i_enable` rises, the generator starts at (h,v) = (0,0) on that cycle.
- Enable drop mid-frame: counters return to 0 on the next cycle. Entries already in the delay line drain normally, so outputs go idle MEM_LAT+1 cycles later. No partial-frame resume.

## Timing
- Reset values:
  - `o_hsync` and `o_vsync` = `~SYNC_POL`.
  - `o_de`, `o_rd_en`, `o_frame_start`, `o_rd_addr` and RGB = 0.
  - All delay-line stages are cleared to the inactive state.
- Latency from counter position to outputs is MEM_LAT+1 cycles, fixed for all outputs. The relative phase of `hsync`, `vsync` and `de` matches the counter domain exactly.
- `o_frame_start` asserts for exactly 1 cycle per frame, on the cycle `o_de` first rises in the frame.
- Wrap: `h_cnt = H_TOTAL-1` and `v_cnt = V_TOTAL-1` wrap to (0,0) in the same cycle.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). After release the generator restarts at (0,0) if enabled.
- One read per active pixel is issued, with no backpressure. The frame buffer must accept a read every cycle.

## Structure
- Package `vga_pkg` holds:
  - the 640x480@60 timing constants;
  - a `vga_timing_t` struct (active/fp/sync/bp per axis);
  - a `pixel_t` packed struct {r,g,b};
  - sync-polarity constants.
- Sub-module `vga_timing_gen` contains the counters, sync windows and active flag, with outputs registered at counter time.
- The top level adds address generation, the MEM_LAT delay line (a shift register indexed by parameter) and the output register.

## Test plan
All scenarios use small timing: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), MEM_LAT 2, SYNC_POL 0, and a memory model that returns `addr` replicated on R, G and B.
- **Reset:** hold `rstn`=0 → `o_hsync`=`o_vsync`=1, `o_de`=0, RGB=0. Release with `i_enable`=1 → first `o_de` rises 3 cycles after the first `o_rd_en`.
- **Pixel order, SCALE_SH=0:**
  - Line 0 outputs R values 0..7; line 3 outputs 24..31.
  - `o_frame_start` pulses only with pixel 0.
  - Exactly 32 `o_de` cycles per 98-cycle frame.
- **Pixel order, SCALE_SH=1:**
  - Lines 0 and 1 both output 0,0,1,1,2,2,3,3.
  - Lines 2 and 3 output 4,4,5,5,6,6,7,7.
  - The maximum address is 7.
- **Sync windows:** `o_hsync` is low for 2 cycles starting 10 cycles after `o_de` rises on each line. `o_vsync` is low for exactly 14 cycles per frame, starting on output line 5.
- **Enable drop:** drop `i_enable` at line 1, pixel 3 → `o_rd_en` is 0 next cycle, the 3 in-flight pixels still appear, then `o_de` stays 0. Re-enable → the next output pixel is address 0 with an `o_frame_start` pulse.
- **Mid-frame reset:** assert `rstn`=0 during active video → outputs drop to reset values that same cycle. After release, output restarts from address 0.
